// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and helpers for the dual-port-RAM FIFO
//                controller: skid-slot record (valid + payload) and the
//                occupancy-count width function.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Payload width carried by a skid slot; the controller's DATA_WIDTH must
  // match it.
  localparam int unsigned c_slot_width = 32;

  typedef struct packed {
    logic                    valid;
    logic [c_slot_width-1:0] data;
  } skid_slot_t;

  // Total occupancy reaches DEPTH + 2, so two extra bits over the address.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_ram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dp_ram_fifo_ctrl_if
//  Description : Producer/consumer stream bundle of the FIFO controller.
//                master : drives wr_valid/wr_data/rd_ready (traffic source)
//                slave  : the FIFO controller itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface dp_ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/fifo_skid2.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_skid2
//  Description : Two-slot output skid buffer (S0 = head, S1 behind it).
//                Ports: CLKA, rst_n (sync, active-low); cap_valid/cap_data
//                load returning RAM data; pop removes the head;
//                head_valid/head_data expose S0; occupancy = valid slots.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_skid2
  import fifo_pkg::*;
(
  input  logic                    CLKA,
  input  logic                    rst_n,
  input  logic                    cap_valid,
  input  logic [c_slot_width-1:0] cap_data,
  input  logic                    pop,
  output logic                    head_valid,
  output logic [c_slot_width-1:0] head_data,
  output logic [1:0]              occupancy
);

  skid_slot_t r_s0, r_s1;
  skid_slot_t w_s0, w_s1;

  // Apply the pop first, then drop the capture into the lowest free slot of
  // the post-pop state, so a simultaneous pop and capture keep order.
  always_comb begin
    w_s0 = pop ? r_s1 : r_s0;
    w_s1 = r_s1;
    if (pop) begin
      w_s1.valid = 1'b0;
    end
    if (cap_valid) begin
      if (!w_s0.valid) begin
        w_s0.valid = 1'b1;
        w_s0.data  = cap_data;
      end else begin
        w_s1.valid = 1'b1;
        w_s1.data  = cap_data;
      end
    end
  end

  // Only the valid flags are reset; payloads simply follow.
  always_ff @(posedge CLKA) begin
    if (!rst_n) begin
      r_s0.valid <= 1'b0;
      r_s1.valid <= 1'b0;
    end else begin
      r_s0.valid <= w_s0.valid;
      r_s1.valid <= w_s1.valid;
    end
    r_s0.data <= w_s0.data;
    r_s1.data <= w_s1.data;
  end

  assign head_valid = r_s0.valid;
  assign head_data  = r_s0.data;
  assign occupancy  = {1'b0, r_s0.valid} + {1'b0, r_s1.valid};

endmodule
`default_nettype wire

// File: rtl/dp_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dp_ram_fifo_ctrl
//  Description : First-word-fall-through FIFO built on an external dual-port
//                RAM (DEPTH = 2**ADDR_WIDTH) plus a 2-entry output skid,
//                total capacity DEPTH + 2.
//                Ports: CLKA, rst_n (sync, active-low); bus (stream slave);
//                count = total occupancy; ram_AA/ram_CEA read port,
//                ram_AB/ram_CEB/ram_DB/ram_BWB write port, ram_QA read data
//                (one-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module dp_ram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = c_slot_width
) (
  input  logic                               CLKA,
  input  logic                               rst_n,
  dp_ram_fifo_ctrl_if.slave                  bus,
  output logic [count_width(ADDR_WIDTH)-1:0] count,
  output logic [ADDR_WIDTH-1:0]              ram_AA,
  output logic                               ram_CEA,
  output logic [ADDR_WIDTH-1:0]              ram_AB,
  output logic                               ram_CEB,
  output logic [DATA_WIDTH-1:0]              ram_DB,
  output logic [DATA_WIDTH-1:0]              ram_BWB,
  input  logic [DATA_WIDTH-1:0]              ram_QA
);

  localparam int unsigned           c_depth    = 2 ** ADDR_WIDTH;
  localparam int unsigned           c_cnt_w    = count_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   c_ram_full = (ADDR_WIDTH + 1)'(c_depth);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_inflight;
  logic [c_cnt_w-1:0]    r_count;

  logic                  w_wr_fire;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_head_valid;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [1:0]            w_skid_occ;
  logic [2:0]            w_pending;

  assign bus.wr_ready = rst_n && (r_ram_cnt != c_ram_full);
  assign bus.rd_valid = rst_n && w_head_valid;
  assign bus.rd_data  = w_head_data;

  assign w_wr_fire = bus.wr_valid && bus.wr_ready;
  assign w_pop     = bus.rd_valid && bus.rd_ready;

  // Skid entries that will be held once this cycle's pop and the returning
  // read are accounted for. Crediting the same-cycle pop lets a read issue
  // every cycle while the consumer drains, sustaining one entry per cycle.
  assign w_pending = {1'b0, w_skid_occ} - {2'b00, w_pop} + {2'b00, r_inflight};

  // r_ram_cnt excludes this cycle's write, so a freshly written word is read
  // no earlier than the next cycle and read/write addresses never collide.
  assign w_issue = rst_n && (r_ram_cnt != '0) && (w_pending < 3'd2);

  assign ram_CEA = w_issue;
  assign ram_AA  = r_rd_ptr;
  assign ram_CEB = w_wr_fire;
  assign ram_AB  = r_wr_ptr;
  assign ram_DB  = bus.wr_data;
  assign ram_BWB = {DATA_WIDTH{1'b1}};

  assign count = r_count;

  always_ff @(posedge CLKA) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_wr_fire) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_ram_cnt  <= r_ram_cnt + (ADDR_WIDTH + 1)'(w_wr_fire)
                              - (ADDR_WIDTH + 1)'(w_issue);
      r_inflight <= w_issue;
      r_count    <= r_count + c_cnt_w'(w_wr_fire) - c_cnt_w'(w_pop);
    end
  end

  fifo_skid2 u_skid (
    .CLKA       (CLKA),
    .rst_n      (rst_n),
    .cap_valid  (r_inflight),
    .cap_data   (ram_QA),
    .pop        (w_pop),
    .head_valid (w_head_valid),
    .head_data  (w_head_data),
    .occupancy  (w_skid_occ)
  );

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dp_ram_fifo_ctrl
//  Description : Directed self-checking bench for dp_ram_fifo_ctrl with a
//                behavioural dual-port RAM and an ordering scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_ram_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CAP   = DEPTH + 2;

  logic          CLKA;
  logic          rst_n;
  logic [AW+1:0] count;
  logic [AW-1:0] ram_AA, ram_AB;
  logic          ram_CEA, ram_CEB;
  logic [DW-1:0] ram_DB, ram_BWB, ram_QA;

  dp_ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  dp_ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLKA    (CLKA),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .count   (count),
    .ram_AA  (ram_AA),
    .ram_CEA (ram_CEA),
    .ram_AB  (ram_AB),
    .ram_CEB (ram_CEB),
    .ram_DB  (ram_DB),
    .ram_BWB (ram_BWB),
    .ram_QA  (ram_QA)
  );

  initial CLKA = 1'b0;
  always #5 CLKA = ~CLKA;

  // Behavioural RAM; read data is poisoned whenever no read was issued.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge CLKA) begin
    if (ram_CEB) mem[ram_AB] <= ram_DB;
    ram_QA <= ram_CEA ? mem[ram_AA] : 32'hDEAD_BEEF;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLKA);
    #1;
  endtask

  // Scoreboard and invariant monitor, sampled mid-cycle.
  always @(negedge CLKA) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check_eq("count_model", 64'(count), 64'(exp_q.size()));
      if (ram_CEA && ram_CEB && ram_AA == ram_AB) viol++;
      if (ram_CEB && ram_BWB != {DW{1'b1}}) viol++;
      if (count > CAP) viol++;
      if (bus.wr_valid && bus.wr_ready) begin
        exp_q.push_back(bus.wr_data);
        acc_cnt++;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("pop_underflow", 64'd1, 64'd0);
        end else begin
          check_eq("pop_data", 64'(bus.rd_data), 64'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int a0, p0, cyc;
    logic stale;

    // ---------------- reset ----------------
    rst_n        = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h1234_5678;
    bus.rd_ready = 1'b1;
    step();
    check_eq("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check_eq("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    check_eq("rst_cea", 64'(ram_CEA), 64'd0);
    check_eq("rst_ceb", 64'(ram_CEB), 64'd0);
    step();
    rst_n        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    #1;
    check_eq("post_rst_count", 64'(count), 64'd0);
    check_eq("post_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check_eq("post_rst_wr_ready", 64'(bus.wr_ready), 64'd1);

    // ---------------- single write latency ----------------
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h0000_00A5;
    #1;
    check_eq("wr_ceb", 64'(ram_CEB), 64'd1);
    check_eq("wr_ab", 64'(ram_AB), 64'd0);
    check_eq("wr_db", 64'(ram_DB), 64'h0A5);
    check_eq("wr_bwb", 64'(ram_BWB), 64'hFFFF_FFFF);
    step();                                   // accept edge
    bus.wr_valid = 1'b0;
    #1;
    check_eq("lat1_rd_valid", 64'(bus.rd_valid), 64'd0);
    check_eq("lat1_cea", 64'(ram_CEA), 64'd1);
    check_eq("lat1_aa", 64'(ram_AA), 64'd0);
    check_eq("lat1_count", 64'(count), 64'd1);
    step();                                   // issue edge
    check_eq("lat2_rd_valid", 64'(bus.rd_valid), 64'd0);
    step();                                   // capture edge
    check_eq("lat3_rd_valid", 64'(bus.rd_valid), 64'd1);
    check_eq("lat3_rd_data", 64'(bus.rd_data), 64'h0A5);
    check_eq("lat3_count", 64'(count), 64'd1);
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
    #1;
    check_eq("pop1_rd_valid", 64'(bus.rd_valid), 64'd0);
    check_eq("pop1_count", 64'(count), 64'd0);

    // ---------------- fill to capacity ----------------
    for (int i = 0; i < CAP; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'h100 + 32'(i);
      #1;
      check_eq("fill_wr_ready", 64'(bus.wr_ready), 64'd1);
      step();
    end
    check_eq("full_wr_ready", 64'(bus.wr_ready), 64'd0);
    check_eq("full_count", 64'(count), 64'(CAP));
    bus.wr_data = 32'h0000_0BAD;              // 19th offer, must be ignored
    #1;
    check_eq("full_ceb", 64'(ram_CEB), 64'd0);
    step();
    step();
    check_eq("full_count_hold", 64'(count), 64'(CAP));
    check_eq("full_head_hold", 64'(bus.rd_data), 64'h100);
    check_eq("full_rd_valid", 64'(bus.rd_valid), 64'd1);

    // ---------------- streaming from full ----------------
    a0 = acc_cnt;
    p0 = pop_cnt;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.wr_data = 32'h200 + 32'(acc_cnt - a0);
      check_eq("stream_rd_valid", 64'(bus.rd_valid), 64'd1);
      step();
      check_eq("stream_cnt_range", 64'(count >= 17 && count <= 18), 64'd1);
    end
    check_eq("stream_pops", 64'(pop_cnt - p0), 64'd20);
    check_eq("stream_accepts", 64'(acc_cnt - a0), 64'd19);
    bus.wr_valid = 1'b0;
    cyc = 0;
    while (count != 0 && cyc < 100) begin
      step();
      cyc++;
    end
    check_eq("drain1_count", 64'(count), 64'd0);

    // ---------------- 40 writes, random consumer ----------------
    a0 = acc_cnt;
    p0 = pop_cnt;
    cyc = 0;
    while (((acc_cnt - a0) < 40 || count != 0) && cyc < 400) begin
      bus.wr_valid = ((acc_cnt - a0) < 40);
      bus.wr_data  = 32'h300 + 32'(acc_cnt - a0);
      bus.rd_ready = ((acc_cnt - a0) < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      cyc++;
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    check_eq("wrap_accepts", 64'(acc_cnt - a0), 64'd40);
    check_eq("wrap_pops", 64'(pop_cnt - p0), 64'd40);
    check_eq("wrap_count", 64'(count), 64'd0);

    // ---------------- reset with a read in flight ----------------
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h0000_005A;
    step();
    bus.wr_valid = 1'b0;
    #1;
    check_eq("inflt_cea", 64'(ram_CEA), 64'd1);
    step();                                   // read issued; data returns next
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check_eq("inflt_rd_valid", 64'(bus.rd_valid), 64'd0);
    check_eq("inflt_count", 64'(count), 64'd0);
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rd_valid || ram_CEA) stale = 1'b1;
      step();
    end
    check_eq("inflt_no_stale", 64'(stale), 64'd0);

    check_eq("invariants", 64'(viol), 64'd0);
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
